// File: rtl/operand_forward_unit_pkg.sv
// operand_forward_unit_pkg: select codes, instruction field positions and scoreboard entry type
package operand_forward_unit_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;
  localparam int OP1_HI = 11;
  localparam int OP1_LO = 8;
  localparam int OP2_HI = 7;
  localparam int OP2_LO = 4;
  localparam int SB_REG_W = OP1_HI - OP1_LO + 1;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic m_read;
    logic [SB_REG_W-1:0] dest;
  } sb_entry_t;
endpackage

// File: rtl/operand_forward_unit_if.sv
// operand_forward_unit_if: ID-side instruction feed and EX-side forwarding outputs
interface operand_forward_unit_if #(
  parameter int INSTR_W = 16,
  parameter int REG_W = 4
);
  logic [INSTR_W-1:0] id_instr;
  logic id_valid;
  logic id_regWrite;
  logic id_mRead;
  logic IFIDWrite;
  logic flush;
  logic [1:0] fwdA;
  logic [1:0] fwdB;
  logic ex_mRead;
  logic [REG_W-1:0] ex_dest;
  logic hazard_err;
  modport master (
    output id_instr, id_valid, id_regWrite, id_mRead, IFIDWrite, flush,
    input fwdA, fwdB, ex_mRead, ex_dest, hazard_err
  );
  modport slave (
    input id_instr, id_valid, id_regWrite, id_mRead, IFIDWrite, flush,
    output fwdA, fwdB, ex_mRead, ex_dest, hazard_err
  );
endinterface

// File: rtl/operand_forward_unit_fwd_select.sv
// operand_forward_unit_fwd_select: youngest-first producer match for one source register
module operand_forward_unit_fwd_select
  import operand_forward_unit_pkg::*;
#(
  parameter bit ZERO_FWD = 1'b0
) (
  input  logic [SB_REG_W-1:0] src,
  input  logic                in_valid,
  input  sb_entry_t           ex_e,
  input  sb_entry_t           mem_e,
  input  sb_entry_t           wb_e,
  output logic [1:0]          sel,
  output logic                load_use
);
  logic ok, hit_ex, hit_mem, hit_wb;
  // a load still in EX cannot be forwarded, so it forces the register file and flags a missed stall
  always_comb begin
    ok = in_valid && (ZERO_FWD || src != '0);
    hit_ex = ok && ex_e.valid && ex_e.reg_write && ex_e.dest == src;
    hit_mem = ok && mem_e.valid && mem_e.reg_write && mem_e.dest == src;
    hit_wb = ok && wb_e.valid && wb_e.reg_write && wb_e.dest == src;
    load_use = hit_ex && ex_e.m_read;
    sel = hit_ex ? (ex_e.m_read ? FWD_RF : FWD_EXMEM) :
          hit_mem ? FWD_MEMWB : hit_wb ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/operand_forward_unit.sv
// operand_forward_unit: registered EX operand forward selects from a 3-entry destination scoreboard
module operand_forward_unit
  import operand_forward_unit_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_W = 4,
  parameter bit ZERO_FWD = 1'b0
) (
  input logic clk,
  input logic reset,
  operand_forward_unit_if.slave bus
);
  logic [INSTR_W-1:0] instr;
  logic unused_bits;
  sb_entry_t in_e, ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic [1:0] sel_a, sel_b, fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic lu_a, lu_b, err_d, err_q;
  assign instr = bus.id_instr;
  assign unused_bits = ^{instr[INSTR_W-1:OP1_HI+1], instr[OP2_LO-1:0]};
  operand_forward_unit_fwd_select #(.ZERO_FWD(ZERO_FWD)) u_sel_a (
    .src(instr[OP1_HI:OP1_LO]), .in_valid(in_e.valid),
    .ex_e(ex_q), .mem_e(mem_q), .wb_e(wb_q), .sel(sel_a), .load_use(lu_a)
  );
  operand_forward_unit_fwd_select #(.ZERO_FWD(ZERO_FWD)) u_sel_b (
    .src(instr[OP2_HI:OP2_LO]), .in_valid(in_e.valid),
    .ex_e(ex_q), .mem_e(mem_q), .wb_e(wb_q), .sel(sel_b), .load_use(lu_b)
  );
  // stalls, flushes and invalid slots enter EX as all-zero bubbles; the scoreboard shifts every cycle
  always_comb begin
    in_e = (bus.IFIDWrite && !bus.flush && bus.id_valid) ?
           '{valid: 1'b1, reg_write: bus.id_regWrite, m_read: bus.id_mRead, dest: instr[OP1_HI:OP1_LO]} : '0;
    ex_d = in_e;
    mem_d = ex_q;
    wb_d = mem_q;
    fwd_a_d = sel_a;
    fwd_b_d = sel_b;
    err_d = err_q || lu_a || lu_b;
  end
  // scoreboard, selects and sticky error all clear immediately on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      err_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      err_q <= err_d;
    end
  assign bus.fwdA = fwd_a_q;
  assign bus.fwdB = fwd_b_q;
  assign bus.ex_mRead = ex_q.m_read;
  assign bus.ex_dest = REG_W'(ex_q.dest);
  assign bus.hazard_err = err_q;
endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: directed scoreboard bench for the operand forwarding unit
module tb_operand_forward_unit;
  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic err;
    logic mr;
    logic [3:0] dest;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int n = 0;
  exp_t q[$];
  operand_forward_unit_if bus ();
  operand_forward_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".fwdA"}, {2'b00, bus.fwdA}, 4'h0);
    chk({tag, ".fwdB"}, {2'b00, bus.fwdB}, 4'h0);
    chk({tag, ".err"}, {3'b000, bus.hazard_err}, 4'h0);
    chk({tag, ".ex_mRead"}, {3'b000, bus.ex_mRead}, 4'h0);
    chk({tag, ".ex_dest"}, bus.ex_dest, 4'h0);
  endtask

  task automatic step(input logic [15:0] instr, input logic valid, input logic rw, input logic mr,
                      input logic ifid, input logic fl, input logic [1:0] ea, input logic [1:0] eb,
                      input logic eerr);
    exp_t e;
    logic bub;
    bub = !valid || !ifid || fl;
    bus.id_instr = instr;
    bus.id_valid = valid;
    bus.id_regWrite = rw;
    bus.id_mRead = mr;
    bus.IFIDWrite = ifid;
    bus.flush = fl;
    e.a = ea;
    e.b = eb;
    e.err = eerr;
    e.mr = bub ? 1'b0 : mr;
    e.dest = bub ? 4'h0 : instr[11:8];
    q.push_back(e);
    @(posedge clk);
    #1;
    n++;
    e = q.pop_front();
    chk($sformatf("s%0d.fwdA", n), {2'b00, bus.fwdA}, {2'b00, e.a});
    chk($sformatf("s%0d.fwdB", n), {2'b00, bus.fwdB}, {2'b00, e.b});
    chk($sformatf("s%0d.err", n), {3'b000, bus.hazard_err}, {3'b000, e.err});
    chk($sformatf("s%0d.ex_mRead", n), {3'b000, bus.ex_mRead}, {3'b000, e.mr});
    chk($sformatf("s%0d.ex_dest", n), bus.ex_dest, e.dest);
  endtask

  initial begin
    bus.id_instr = '0;
    bus.id_valid = 1'b0;
    bus.id_regWrite = 1'b0;
    bus.id_mRead = 1'b0;
    bus.IFIDWrite = 1'b1;
    bus.flush = 1'b0;
    #1;
    check_all_zero("reset");
    #1 reset = 1'b1;
    // non-writing instructions never forward
    step(16'h1100, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1210, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1320, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    // EX-to-EX
    step(16'h1300, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h2530, 1, 1, 0, 1, 0, 2'b00, 2'b01, 0);
    // two back
    step(16'h1600, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1700, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h2860, 1, 0, 0, 1, 0, 2'b00, 2'b10, 0);
    // three back
    step(16'h1900, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1a00, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1b00, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h2c90, 1, 0, 0, 1, 0, 2'b00, 2'b11, 0);
    // four back is out of range
    step(16'h1d00, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1e00, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1f00, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1100, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h22d0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    // youngest writer wins
    step(16'h1400, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h1400, 1, 1, 0, 1, 0, 2'b01, 2'b00, 0);
    step(16'h2450, 1, 0, 0, 1, 0, 2'b01, 2'b00, 0);
    // stalled load-use
    step(16'h1200, 1, 1, 1, 1, 0, 2'b00, 2'b00, 0);
    step(16'h3120, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    step(16'h3120, 1, 0, 0, 1, 0, 2'b00, 2'b10, 0);
    // missed stall; the repeated load also reads r2 from the WB slot
    step(16'h1200, 1, 1, 1, 1, 0, 2'b11, 2'b00, 0);
    step(16'h3120, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    // flushed writer and invalid slot leave nothing to forward
    step(16'h1500, 1, 1, 0, 1, 1, 2'b00, 2'b00, 1);
    step(16'h1600, 0, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    step(16'h2550, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    step(16'h2260, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    // register 0 is never forwarded
    step(16'h1000, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    step(16'h2000, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    // mid-stream reset
    step(16'h1600, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    step(16'h1700, 1, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    bus.id_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    #1 reset = 1'b1;
    step(16'h2760, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    step(16'h2670, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
